// File: rtl/matrix_alu_engine_if.sv
// ALU-side bus of the matrix engine: control handshake from the top-level FSM plus the
// matrix-memory read/write/dimension ports. master = engine, slave = control + memory.
interface matrix_alu_engine_if #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 3
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] scalar;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        alu_rd_slot;
  logic [DIM_W-1:0]  alu_rd_row;
  logic [DIM_W-1:0]  alu_rd_col;
  logic [DATA_W-1:0] alu_rd_data;
  logic [DIM_W-1:0]  alu_current_m;
  logic [DIM_W-1:0]  alu_current_n;
  logic [1:0]        alu_wr_slot;
  logic [DIM_W-1:0]  alu_wr_row;
  logic [DIM_W-1:0]  alu_wr_col;
  logic [DATA_W-1:0] alu_wr_data;
  logic              alu_wr_we;
  logic [DIM_W-1:0]  alu_res_m;
  logic [DIM_W-1:0]  alu_res_n;
  logic              alu_dim_we;

  modport master (
    input  start, op, scalar, alu_rd_data, alu_current_m, alu_current_n,
    output busy, done, err, alu_rd_slot, alu_rd_row, alu_rd_col,
           alu_wr_slot, alu_wr_row, alu_wr_col, alu_wr_data, alu_wr_we,
           alu_res_m, alu_res_n, alu_dim_we
  );

  modport slave (
    output start, op, scalar, alu_rd_data, alu_current_m, alu_current_n,
    input  busy, done, err, alu_rd_slot, alu_rd_row, alu_rd_col,
           alu_wr_slot, alu_wr_row, alu_wr_col, alu_wr_data, alu_wr_we,
           alu_res_m, alu_res_n, alu_dim_we
  );
endinterface

// File: rtl/matrix_alu_engine.sv
// Matrix ALU sequencer: C = A+B, A*scalar, A^T or A*B over the matrix memory ALU ports.
// Define MATRIX_ALU_SAT_EN to saturate products/sums at 2^DATA_W-1 instead of wrapping.
module matrix_alu_engine #(
  parameter int DATA_W  = 16,
  parameter int DIM_W   = 3,
  parameter int MAX_DIM = 5
) (
  input logic                 clk,
  input logic                 rst,
  matrix_alu_engine_if.master bus
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SCL = 2'd1;
  localparam logic [1:0] OP_TRN = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_DIM_A, S_DIM_B, S_CHECK, S_RUN, S_DIM_WR, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_scalar;
  logic [DATA_W-1:0] r_lat;
  logic [DATA_W-1:0] r_acc;
  logic [DIM_W-1:0]  r_ma, r_na, r_mb, r_nb;
  logic [DIM_W-1:0]  r_i, r_j, r_k;
  logic [DIM_W-1:0]  r_res_m, r_res_n;
  logic              r_ph;
  logic              r_busy, r_done, r_err, r_dim_we;

  function automatic logic f_dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

  function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef MATRIX_ALU_SAT_EN
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] f_mul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = a * b;
`ifdef MATRIX_ALU_SAT_EN
    return (|p[2*DATA_W-1:DATA_W]) ? '1 : p[DATA_W-1:0];
`else
    return p[DATA_W-1:0];
`endif
  endfunction

  logic              w_legal;
  logic [DIM_W-1:0]  w_res_m, w_res_n;
  logic [DIM_W-1:0]  w_lim_j;
  logic              w_last_i, w_last_j, w_last_k;
  logic              w_elem_done;
  logic [DATA_W-1:0] w_prod, w_sum;

  // SCALAR multiplies by the latched scalar, MUL by the latched A element
  assign w_prod = f_mul((r_op == OP_SCL) ? r_scalar : r_lat, bus.alu_rd_data);
  assign w_sum  = (r_op == OP_MUL) ? f_add(r_acc, w_prod) : f_add(r_lat, bus.alu_rd_data);

  assign w_lim_j  = (r_op == OP_MUL) ? r_nb : r_na;
  assign w_last_i = (r_i == r_ma - DIM_W'(1));
  assign w_last_j = (r_j == w_lim_j - DIM_W'(1));
  assign w_last_k = (r_k == r_na - DIM_W'(1));

  always_comb begin
    case (r_op)
      OP_ADD:  w_elem_done = r_ph;
      OP_MUL:  w_elem_done = r_ph && w_last_k;
      default: w_elem_done = 1'b1;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    w_res_m = '0;
    w_res_n = '0;
    case (r_op)
      OP_ADD: begin
        w_legal = f_dim_ok(r_ma) && f_dim_ok(r_na) && (r_ma == r_mb) && (r_na == r_nb);
        w_res_m = r_ma;
        w_res_n = r_na;
      end
      OP_SCL: begin
        w_legal = f_dim_ok(r_ma) && f_dim_ok(r_na);
        w_res_m = r_ma;
        w_res_n = r_na;
      end
      OP_TRN: begin
        w_legal = f_dim_ok(r_ma) && f_dim_ok(r_na);
        w_res_m = r_na;
        w_res_n = r_ma;
      end
      default: begin
        w_legal = f_dim_ok(r_ma) && f_dim_ok(r_na) && f_dim_ok(r_mb) && f_dim_ok(r_nb)
                  && (r_na == r_mb);
        w_res_m = r_ma;
        w_res_n = r_nb;
      end
    endcase
  end

  // Read and write addresses follow the registered state: memory reads are same-cycle
  always_comb begin
    bus.alu_rd_slot = 2'd0;
    bus.alu_rd_row  = '0;
    bus.alu_rd_col  = '0;
    bus.alu_wr_row  = '0;
    bus.alu_wr_col  = '0;
    bus.alu_wr_data = '0;
    bus.alu_wr_we   = 1'b0;
    case (r_state)
      S_DIM_B: bus.alu_rd_slot = 2'd1;
      S_RUN: begin
        case (r_op)
          OP_ADD: begin
            bus.alu_rd_slot = {1'b0, r_ph};
            bus.alu_rd_row  = r_i;
            bus.alu_rd_col  = r_j;
            bus.alu_wr_row  = r_i;
            bus.alu_wr_col  = r_j;
            bus.alu_wr_data = w_sum;
            bus.alu_wr_we   = r_ph;
          end
          OP_SCL: begin
            bus.alu_rd_row  = r_i;
            bus.alu_rd_col  = r_j;
            bus.alu_wr_row  = r_i;
            bus.alu_wr_col  = r_j;
            bus.alu_wr_data = w_prod;
            bus.alu_wr_we   = 1'b1;
          end
          OP_TRN: begin
            bus.alu_rd_row  = r_i;
            bus.alu_rd_col  = r_j;
            bus.alu_wr_row  = r_j;
            bus.alu_wr_col  = r_i;
            bus.alu_wr_data = bus.alu_rd_data;
            bus.alu_wr_we   = 1'b1;
          end
          default: begin
            bus.alu_rd_slot = {1'b0, r_ph};
            bus.alu_rd_row  = r_ph ? r_k : r_i;
            bus.alu_rd_col  = r_ph ? r_j : r_k;
            bus.alu_wr_row  = r_i;
            bus.alu_wr_col  = r_j;
            bus.alu_wr_data = w_sum;
            bus.alu_wr_we   = r_ph && w_last_k;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_scalar <= '0;
      r_lat    <= '0;
      r_acc    <= '0;
      r_ma     <= '0;
      r_na     <= '0;
      r_mb     <= '0;
      r_nb     <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_res_m  <= '0;
      r_res_n  <= '0;
      r_ph     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_dim_we <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_dim_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_scalar <= bus.scalar;
            r_busy   <= 1'b1;
            r_state  <= S_DIM_A;
          end
        end
        S_DIM_A: begin
          r_ma    <= bus.alu_current_m;
          r_na    <= bus.alu_current_n;
          r_state <= S_DIM_B;
        end
        S_DIM_B: begin
          r_mb    <= bus.alu_current_m;
          r_nb    <= bus.alu_current_n;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_res_m <= w_res_m;
          r_res_n <= w_res_n;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_ph    <= 1'b0;
          r_acc   <= '0;
          r_lat   <= '0;
          if (w_legal) begin
            r_state <= S_RUN;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_RUN: begin
          if ((r_op == OP_ADD) || (r_op == OP_MUL)) r_ph <= ~r_ph;
          if (!r_ph) r_lat <= bus.alu_rd_data;
          if ((r_op == OP_MUL) && r_ph) begin
            if (w_last_k) begin
              r_k   <= '0;
              r_acc <= '0;
            end else begin
              r_k   <= r_k + DIM_W'(1);
              r_acc <= w_sum;
            end
          end
          if (w_elem_done) begin
            if (w_last_j) begin
              r_j <= '0;
              if (w_last_i) begin
                r_dim_we <= 1'b1;
                r_state  <= S_DIM_WR;
              end else begin
                r_i <= r_i + DIM_W'(1);
              end
            end else begin
              r_j <= r_j + DIM_W'(1);
            end
          end
        end
        S_DIM_WR: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.alu_dim_we  = r_dim_we;
  assign bus.alu_res_m   = r_res_m;
  assign bus.alu_res_n   = r_res_n;
  assign bus.alu_wr_slot = 2'd2;

endmodule

// File: tb/tb_matrix_alu_engine.sv
// Directed bench for matrix_alu_engine with a behavioural three-slot matrix memory.
module tb_matrix_alu_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_alu_engine_if bus ();

  matrix_alu_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] memA [25];
  logic [15:0] memB [25];
  logic [15:0] memC [25];
  logic [2:0]  mA = 3'd0, nA = 3'd0, mB = 3'd0, nB = 3'd0, mC = 3'd0, nC = 3'd0;
  logic        clr_c = 1'b0;
  int          wr_cnt = 0, dim_cnt = 0, err_cnt = 0;
  int          n_chk = 0, n_fail = 0;

  always_comb begin
    int ridx;
    ridx = int'(bus.alu_rd_row) * 5 + int'(bus.alu_rd_col);
    bus.alu_rd_data   = 16'd0;
    bus.alu_current_m = 3'd0;
    bus.alu_current_n = 3'd0;
    case (bus.alu_rd_slot)
      2'd0: begin
        if (ridx < 25) bus.alu_rd_data = memA[ridx];
        bus.alu_current_m = mA;
        bus.alu_current_n = nA;
      end
      2'd1: begin
        if (ridx < 25) bus.alu_rd_data = memB[ridx];
        bus.alu_current_m = mB;
        bus.alu_current_n = nB;
      end
      2'd2: begin
        if (ridx < 25) bus.alu_rd_data = memC[ridx];
        bus.alu_current_m = mC;
        bus.alu_current_n = nC;
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    int widx;
    widx = int'(bus.alu_wr_row) * 5 + int'(bus.alu_wr_col);
    if (clr_c) begin
      for (int q = 0; q < 25; q++) memC[q] <= 16'hDEAD;
      mC <= 3'd0;
      nC <= 3'd0;
    end else begin
      if (bus.alu_wr_we) begin
        if (widx < 25) memC[widx] <= bus.alu_wr_data;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.alu_dim_we) begin
        mC <= bus.alu_res_m;
        nC <= bus.alu_res_n;
        dim_cnt <= dim_cnt + 1;
      end
    end
    if (bus.err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_mat(input bit sel_b, input int m, input int n, input int base, input int step);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (sel_b) memB[r*5+c] = 16'(base + step * (r * n + c));
        else       memA[r*5+c] = 16'(base + step * (r * n + c));
      end
    if (sel_b) begin mB = 3'(m); nB = 3'(n); end
    else       begin mA = 3'(m); nA = 3'(n); end
  endtask

  task automatic clear_c();
    @(posedge clk); #1 clr_c = 1'b1;
    @(posedge clk); #1 clr_c = 1'b0;
  endtask

  // Pulses start, then waits for done or err; cyc counts edges since start was sampled
  task automatic run_op(input logic [1:0] o, input logic [15:0] sc, input bit repulse,
                        output int cyc, output bit got_err, output int nwr, output int ndim);
    int w0, d0;
    w0 = wr_cnt;
    d0 = dim_cnt;
    @(posedge clk); #1;
    bus.op = o;
    bus.scalar = sc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && !bus.err && cyc < 2000) begin
      if (repulse && cyc == 5) begin
        bus.start = 1'b1;
        bus.op = 2'd2;
        bus.scalar = 16'd9;
      end else begin
        bus.start = 1'b0;
        bus.op = o;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    if (cyc >= 2000) check("timeout", 32'(cyc), 32'd0);
    got_err = bus.err;
    nwr = wr_cnt - w0;
    ndim = dim_cnt - d0;
  endtask

  int cyc, nwr, ndim, e0;
  bit gerr;
  logic [15:0] exp_scl;
  logic [15:0] mul_exp [4];

  initial begin
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.scalar = 16'd0;
    for (int q = 0; q < 25; q++) begin memA[q] = 16'd0; memB[q] = 16'd0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_we", bus.alu_wr_we, 0);
    check("rst_dimwe", bus.alu_dim_we, 0);
    check("rst_rdaddr", {bus.alu_rd_slot, bus.alu_rd_row, bus.alu_rd_col}, 0);
    check("rst_res", {bus.alu_res_m, bus.alu_res_n}, 0);
    check("wr_slot", bus.alu_wr_slot, 2);

    // ADD 2x3 + 2x3
    set_mat(1'b0, 2, 3, 1, 1);
    set_mat(1'b1, 2, 3, 1, 1);
    clear_c();
    e0 = err_cnt;
    run_op(2'd0, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    check("add_cyc", cyc, 17);
    check("add_err", err_cnt - e0, 0);
    check("add_nwr", nwr, 6);
    check("add_dims", {mC, nC}, {3'd2, 3'd3});
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("add_c%0d%0d", r, c), memC[r*5+c], 2 * (r * 3 + c + 1));

    // ADD again with start re-pulsed mid-run (different op on the bus)
    clear_c();
    run_op(2'd0, 16'd0, 1'b1, cyc, gerr, nwr, ndim);
    check("rep_cyc", cyc, 17);
    check("rep_nwr", nwr, 6);
    check("rep_c12", memC[1*5+2], 12);
    check("rep_c00", memC[0], 2);
    @(posedge clk); #1;
    check("rep_idle", bus.busy, 0);

    // MUL 2x3 * 3x2
    set_mat(1'b1, 3, 2, 7, 1);
    clear_c();
    run_op(2'd3, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    mul_exp = '{16'd58, 16'd64, 16'd139, 16'd154};
    check("mul_cyc", cyc, 29);
    check("mul_nwr", nwr, 4);
    check("mul_dims", {mC, nC}, {3'd2, 3'd2});
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("mul_c%0d%0d", r, c), memC[r*5+c], mul_exp[r*2+c]);
    check("mul_untouched", memC[2], 16'hDEAD);

    // TRANSPOSE 2x3 -> 3x2
    clear_c();
    run_op(2'd2, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    check("trn_cyc", cyc, 11);
    check("trn_nwr", nwr, 6);
    check("trn_dims", {mC, nC}, {3'd3, 3'd2});
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("trn_c%0d%0d", r, c), memC[r*5+c], c * 3 + r + 1);

    // SCALAR 3 on 1x1 {0x6000}
`ifdef MATRIX_ALU_SAT_EN
    exp_scl = 16'hFFFF;
`else
    exp_scl = 16'h2000;
`endif
    set_mat(1'b0, 1, 1, 16'h6000, 0);
    clear_c();
    run_op(2'd1, 16'd3, 1'b0, cyc, gerr, nwr, ndim);
    check("scl_cyc", cyc, 6);
    check("scl_c00", memC[0], exp_scl);
    check("scl_dims", {mC, nC}, {3'd1, 3'd1});

    // Error cases: ADD 2x2 vs 2x3, MUL 2x3 vs 2x2, SCALAR with A 0x2
    set_mat(1'b0, 2, 2, 1, 1);
    set_mat(1'b1, 2, 3, 1, 1);
    clear_c();
    run_op(2'd0, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    check("eadd_err", gerr, 1);
    check("eadd_cyc", cyc, 4);
    check("eadd_we", {16'(nwr), 16'(ndim)}, 0);
    set_mat(1'b0, 2, 3, 1, 1);
    set_mat(1'b1, 2, 2, 1, 1);
    run_op(2'd3, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    check("emul_err", gerr, 1);
    check("emul_cyc", cyc, 4);
    check("emul_we", {16'(nwr), 16'(ndim)}, 0);
    set_mat(1'b0, 0, 2, 1, 1);
    run_op(2'd1, 16'd2, 1'b0, cyc, gerr, nwr, ndim);
    check("edim0_err", gerr, 1);
    check("edim0_cyc", cyc, 4);
    check("edim0_we", {16'(nwr), 16'(ndim)}, 0);
    @(posedge clk); #1;
    check("err_pulse", bus.err, 0);
    check("err_dims", {mC, nC}, 0);

    // Reset during a MUL run
    set_mat(1'b0, 2, 3, 1, 1);
    set_mat(1'b1, 3, 2, 7, 1);
    @(posedge clk); #1 bus.op = 2'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rrun_busy", bus.busy, 0);
    check("rrun_we", bus.alu_wr_we, 0);
    check("rrun_ctl", {bus.done, bus.err, bus.alu_dim_we}, 0);
    check("rrun_rd", {bus.alu_rd_slot, bus.alu_rd_row, bus.alu_rd_col}, 0);
    check("rrun_wr", {bus.alu_wr_row, bus.alu_wr_col, bus.alu_wr_data}, 0);
    check("rrun_res", {bus.alu_res_m, bus.alu_res_n}, 0);

    // MUL 5x5 all ones, then back-to-back SCALAR 2
    set_mat(1'b0, 5, 5, 1, 0);
    set_mat(1'b1, 5, 5, 1, 0);
    clear_c();
    run_op(2'd3, 16'd0, 1'b0, cyc, gerr, nwr, ndim);
    check("m5_cyc", cyc, 255);
    check("m5_nwr", nwr, 25);
    check("m5_dims", {mC, nC}, {3'd5, 3'd5});
    for (int q = 0; q < 25; q++)
      check($sformatf("m5_c%0d", q), memC[(q/5)*5 + (q%5)], 5);
    run_op(2'd1, 16'd2, 1'b0, cyc, gerr, nwr, ndim);
    check("b2b_cyc", cyc, 30);
    check("b2b_nwr", nwr, 25);
    check("b2b_c00", memC[0], 2);
    check("b2b_c44", memC[24], 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
